cross_comm_scheduler: RTL and testbench

//  Round-robin arbiter/sequencer sharing one registered cross-commodity charge datapath among NREQ

---
 rtl/cross_comm_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_cross_comm_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_comm_scheduler.sv
// rtl/cross_comm_scheduler.sv - round-robin sequencer sharing one cross-commodity charge datapath
module cross_comm_scheduler #(
    parameter int NREQ   = 4,
    parameter int DP_LAT = 1,
    parameter int IDW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_rate,
    input  logic [NREQ*16-1:0] req_ratio,
    input  logic [NREQ*8-1:0]  req_inter,
    output logic [15:0]        dp_rate0,
    output logic [15:0]        dp_rate1,
    output logic [7:0]         dp_ratio0,
    output logic [7:0]         dp_ratio1,
    output logic [7:0]         dp_inter,
    input  logic [15:0]        dp_charge,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_charge,
    input  logic               total_clear,
    output logic [31:0]        total_charge,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [15:0]     dp_rate0_q, dp_rate0_d;
    logic [15:0]     dp_rate1_q, dp_rate1_d;
    logic [7:0]      dp_ratio0_q, dp_ratio0_d;
    logic [7:0]      dp_ratio1_q, dp_ratio1_d;
    logic [7:0]      dp_inter_q, dp_inter_d;
    logic [2:0]      lat_q, lat_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_charge_q, rsp_charge_d;
    logic [31:0]     total_q, total_d;

    logic [31:0]     rate_arr  [NREQ];
    logic [15:0]     ratio_arr [NREQ];
    logic [7:0]      inter_arr [NREQ];
    logic            found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx;
    logic [32:0]     sum;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rate_arr[i]  = req_rate[i*32 +: 32];
            ratio_arr[i] = req_ratio[i*16 +: 16];
            inter_arr[i] = req_inter[i*8 +: 8];
        end
    end

    // Scan starts just after the last winner so a just-served requester goes last.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign sum = {1'b0, total_q} + {17'd0, rsp_charge_q};

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        req_ready_d  = '0;
        dp_rate0_d   = dp_rate0_q;
        dp_rate1_d   = dp_rate1_q;
        dp_ratio0_d  = dp_ratio0_q;
        dp_ratio1_d  = dp_ratio1_q;
        dp_inter_d   = dp_inter_q;
        lat_d        = lat_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_charge_d = rsp_charge_q;
        total_d      = total_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_d = NREQ'(1) << grant_idx;
                    dp_rate0_d  = rate_arr[grant_idx][15:0];
                    dp_rate1_d  = rate_arr[grant_idx][31:16];
                    dp_ratio0_d = ratio_arr[grant_idx][7:0];
                    dp_ratio1_d = ratio_arr[grant_idx][15:8];
                    dp_inter_d  = inter_arr[grant_idx];
                    ptr_d       = grant_idx;
                    grant_d     = grant_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = 3'(DP_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == 3'd1) begin
                    rsp_charge_d = dp_charge;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = grant_q;
                    lat_d        = 3'd0;
                    state_d      = RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    total_d     = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear has priority over a same-cycle accumulate.
        if (total_clear) begin
            total_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= IDW'(NREQ - 1);
            grant_q      <= '0;
            req_ready_q  <= '0;
            dp_rate0_q   <= '0;
            dp_rate1_q   <= '0;
            dp_ratio0_q  <= '0;
            dp_ratio1_q  <= '0;
            dp_inter_q   <= '0;
            lat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_charge_q <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            req_ready_q  <= req_ready_d;
            dp_rate0_q   <= dp_rate0_d;
            dp_rate1_q   <= dp_rate1_d;
            dp_ratio0_q  <= dp_ratio0_d;
            dp_ratio1_q  <= dp_ratio1_d;
            dp_inter_q   <= dp_inter_d;
            lat_q        <= lat_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_charge_q <= rsp_charge_d;
            total_q      <= total_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign dp_rate0     = dp_rate0_q;
    assign dp_rate1     = dp_rate1_q;
    assign dp_ratio0    = dp_ratio0_q;
    assign dp_ratio1    = dp_ratio1_q;
    assign dp_inter     = dp_inter_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_charge   = rsp_charge_q;
    assign total_charge = total_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cross_comm_scheduler.sv
// tb/tb_cross_comm_scheduler.sv - directed bench for cross_comm_scheduler
module tb_cross_comm_scheduler;

    localparam int NREQ   = 4;
    localparam int DP_LAT = 1;
    localparam int IDW    = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_rate = '0;
    logic [NREQ*16-1:0] req_ratio = '0;
    logic [NREQ*8-1:0]  req_inter = '0;
    logic [15:0]        dp_rate0, dp_rate1;
    logic [7:0]         dp_ratio0, dp_ratio1, dp_inter;
    logic [15:0]        dp_charge = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_charge;
    logic               total_clear = 1'b0;
    logic [31:0]        total_charge;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cross_comm_scheduler #(.NREQ(NREQ), .DP_LAT(DP_LAT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rate(req_rate), .req_ratio(req_ratio), .req_inter(req_inter),
        .dp_rate0(dp_rate0), .dp_rate1(dp_rate1),
        .dp_ratio0(dp_ratio0), .dp_ratio1(dp_ratio1), .dp_inter(dp_inter),
        .dp_charge(dp_charge),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_charge(rsp_charge),
        .total_clear(total_clear), .total_charge(total_charge), .busy(busy)
    );

    always #5 clk = ~clk;

    // One-stage registered datapath model: ((r0*q0 + r1*q1) * inter) / 100.
    always @(posedge clk) begin
        dp_charge <= 16'(((64'(dp_rate0) * 64'(dp_ratio0) + 64'(dp_rate1) * 64'(dp_ratio1))
                          * 64'(dp_inter)) / 64'd100);
        cyc <= cyc + 1;
    end

    task automatic set_req(input int i, input logic [15:0] r0, input logic [15:0] r1,
                           input logic [7:0] q0, input logic [7:0] q1, input logic [7:0] it);
        req_rate[i*32 +: 32]  = {r1, r0};
        req_ratio[i*16 +: 16] = {q1, q0};
        req_inter[i*8 +: 8]   = it;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; total_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == '0) begin
            errors++;
            $display("FAIL %s: timeout waiting for req_ready", tag);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL %s: timeout waiting for rsp_valid", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_charge, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b valid=%b id=%0d charge=%0d busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_charge, busy);
        end
        checks++;
        if ({dp_rate0, dp_rate1, dp_ratio0, dp_ratio1, dp_inter} !== '0) begin
            errors++;
            $display("FAIL reset_dp: dp_*=%h, want 0", {dp_rate0, dp_rate1, dp_ratio0, dp_ratio1, dp_inter});
        end
        checks++;
        if (total_charge !== 32'd0) begin
            errors++;
            $display("FAIL reset_total: got %h want 0", total_charge);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 16'd100, 16'd200, 8'd1, 8'd1, 8'd50);
        req_valid = 4'b0001;
        wait_ready("t1");
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t1_grant: req_ready=%b want 0001", req_ready);
        end
        checks++;
        if ({dp_rate0, dp_rate1, dp_ratio0, dp_ratio1, dp_inter} !==
            {16'd100, 16'd200, 8'd1, 8'd1, 8'd50}) begin
            errors++;
            $display("FAIL t1_operands: got %0d %0d %0d %0d %0d want 100 200 1 1 50",
                     dp_rate0, dp_rate1, dp_ratio0, dp_ratio1, dp_inter);
        end
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != DP_LAT + 2) begin
            errors++;
            $display("FAIL t1_latency: rsp_valid in cycle %0d want %0d", n, DP_LAT + 2);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_charge !== 16'd150) begin
            errors++;
            $display("FAIL t1_rsp: id=%0d charge=%0d want id 0 charge 150", rsp_id, rsp_charge);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || total_charge !== 32'd150 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_accept: valid=%b total=%0d busy=%b want 0 150 0",
                     rsp_valid, total_charge, busy);
        end
    endtask

    task automatic test_fairness();
        int last;
        int n;
        last = 0;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(10 * (i + 1)), 16'd0, 8'd1, 8'd0, 8'd100);
        req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            wait_ready("t2");
            checks++;
            if (req_ready !== 4'(1 << (g % 4))) begin
                errors++;
                $display("FAIL t2_order: grant %0d req_ready=%b want %b", g, req_ready, 4'(1 << (g % 4)));
            end
            if (g > 0) begin
                checks++;
                if (cyc - last != DP_LAT + 3) begin
                    errors++;
                    $display("FAIL t2_period: %0d cycles between grants want %0d", cyc - last, DP_LAT + 3);
                end
            end
            last = cyc;
            @(negedge clk);
        end
        req_valid = '0;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (total_charge !== 32'd130 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t2_total: total=%0d busy=%b want 130 0", total_charge, busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 16'd1000, 16'd0, 8'd3, 8'd0, 8'd10);
        set_req(1, 16'd7, 16'd0, 8'd1, 8'd0, 8'd100);
        req_valid = 4'b0011;
        wait_ready("t3");
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t3_grant: req_ready=%b want 0001", req_ready);
        end
        req_valid = 4'b0010;
        wait_rsp("t3");
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_charge, busy, req_ready, total_charge} !==
                {1'b1, 2'd0, 16'd300, 1'b1, 4'b0000, 32'd0}) begin
                errors++;
                $display("FAIL t3_hold: k=%0d valid=%b id=%0d charge=%0d busy=%b ready=%b total=%0d want 1 0 300 1 0000 0",
                         k, rsp_valid, rsp_id, rsp_charge, busy, req_ready, total_charge);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0 || total_charge !== 32'd300) begin
            errors++;
            $display("FAIL t3_accept: valid=%b total=%0d want 0 300", rsp_valid, total_charge);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 1'b1;
        force dut.total_q = 32'hFFFF_FD00;
        #1 release dut.total_q;
        set_req(0, 16'd512, 16'd0, 8'd1, 8'd0, 8'd100);
        req_valid = 4'b0001;
        wait_ready("t4a");
        req_valid = '0;
        wait_rsp("t4a");
        @(negedge clk);
        checks++;
        if (total_charge !== 32'hFFFF_FF00) begin
            errors++;
            $display("FAIL t4_preload: total=%h want FFFFFF00", total_charge);
        end
        req_valid = 4'b0001;
        wait_ready("t4b");
        req_valid = '0;
        wait_rsp("t4b");
        @(negedge clk);
        checks++;
        if (total_charge !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL t4_saturate: total=%h want FFFFFFFF", total_charge);
        end
    endtask

    task automatic test_clear_collision();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 16'd100, 16'd200, 8'd1, 8'd1, 8'd50);
        req_valid = 4'b0001;
        wait_ready("t5a");
        req_valid = '0;
        wait_rsp("t5a");
        @(negedge clk);
        checks++;
        if (total_charge !== 32'd150) begin
            errors++;
            $display("FAIL t5_first: total=%0d want 150", total_charge);
        end
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_ready("t5b");
        req_valid = '0;
        wait_rsp("t5b");
        rsp_ready = 1'b1;
        total_clear = 1'b1;
        @(negedge clk);
        total_clear = 1'b0;
        checks++;
        if (total_charge !== 32'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL t5_collision: total=%0d valid=%b want 0 0", total_charge, rsp_valid);
        end
    endtask

    task automatic test_reset_wait();
        int n;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 16'd100, 16'd200, 8'd1, 8'd1, 8'd50);
        set_req(1, 16'd9, 16'd0, 8'd1, 8'd0, 8'd100);
        req_valid = 4'b0001;
        wait_ready("t6a");
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_in_wait: busy=%b valid=%b want 1 0", busy, rsp_valid);
        end
        reset = 1'b1;
        req_valid = 4'b0011;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_charge, busy, total_charge,
             dp_rate0, dp_rate1, dp_ratio0, dp_ratio1, dp_inter} !== '0) begin
            errors++;
            $display("FAIL t6_reset_outputs: ready=%b valid=%b busy=%b total=%0d rate0=%0d want all 0",
                     req_ready, rsp_valid, busy, total_charge, dp_rate0);
        end
        wait_ready("t6b");
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t6_regrant: req_ready=%b want 0001", req_ready);
        end
        req_valid = '0;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (total_charge !== 32'd150) begin
            errors++;
            $display("FAIL t6_total: total=%0d want 150", total_charge);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_clear_collision();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
